// File: rtl/seg_display.sv
// seg_display: 4-digit multiplexed seven-segment hit/miss score display.
// Optional SEG_BLANK_LEADING_ZERO_EN blanks tens digits that are zero.
module seg_display #(
    parameter int DIGIT_HOLD = 1
) (
    input  logic       segclk,
    input  logic       clr,
    input  logic       score0,
    input  logic       score1,
    input  logic       score2,
    input  logic       score3,
    input  logic       score4,
    input  logic       score5,
    input  logic       score6,
    input  logic       score7,
    input  logic       score8,
    input  logic       score9,
    input  logic       score10,
    input  logic       score11,
    input  logic       score12,
    input  logic       score13,
    input  logic       score14,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [15:0] HOLD_LAST = 16'(DIGIT_HOLD - 1);

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_t;

    scan_t       state;
    scan_t       state_nxt;
    logic [14:0] score_q;
    logic [15:0] hold_cnt;
    logic        hold_wrap;
    logic [3:0]  hits;
    logic [3:0]  misses;
    logic [3:0]  hits_tens;
    logic [3:0]  hits_ones;
    logic [3:0]  miss_tens;
    logic [3:0]  miss_ones;
    logic [3:0]  digit_val;
    logic        digit_is_tens;
    logic        digit_blank;
    logic [6:0]  seg_d;
    logic [3:0]  an_d;

    // Active-low g..a pattern for one decimal digit; non-decimal is blank.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] p;
        unique case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Capture all step flags every edge.
    always_ff @(posedge segclk) begin
        if (clr) begin
            score_q <= '0;
        end else begin
            score_q <= {score14, score13, score12, score11, score10,
                        score9,  score8,  score7,  score6,  score5,
                        score4,  score3,  score2,  score1,  score0};
        end
    end

    // Count hits as the population count of the captured flags.
    always_comb begin
        hits = '0;
        for (int i = 0; i < 15; i++) begin
            hits = hits + {3'b000, score_q[i]};
        end
    end

    // Split hits and misses into tens and ones digits.
    always_comb begin
        misses    = 4'd15 - hits;
        hits_tens = (hits >= 4'd10) ? 4'd1 : 4'd0;
        hits_ones = (hits >= 4'd10) ? (hits - 4'd10) : hits;
        miss_tens = (misses >= 4'd10) ? 4'd1 : 4'd0;
        miss_ones = (misses >= 4'd10) ? (misses - 4'd10) : misses;
    end

    // Dwell counter: wraps after DIGIT_HOLD edges on one digit.
    always_ff @(posedge segclk) begin
        if (clr) begin
            hold_cnt <= '0;
        end else if (hold_wrap) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign hold_wrap = (hold_cnt == HOLD_LAST);

    // Scan state register.
    always_ff @(posedge segclk) begin
        if (clr) begin
            state <= SCAN_D0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next scan digit and value selection for the digit being latched now.
    always_comb begin
        state_nxt     = state;
        digit_val     = miss_ones;
        digit_is_tens = 1'b0;
        unique case (state)
            SCAN_D0: begin
                digit_val = miss_ones;
                if (hold_wrap) state_nxt = SCAN_D1;
            end
            SCAN_D1: begin
                digit_val     = miss_tens;
                digit_is_tens = 1'b1;
                if (hold_wrap) state_nxt = SCAN_D2;
            end
            SCAN_D2: begin
                digit_val = hits_ones;
                if (hold_wrap) state_nxt = SCAN_D3;
            end
            SCAN_D3: begin
                digit_val     = hits_tens;
                digit_is_tens = 1'b1;
                if (hold_wrap) state_nxt = SCAN_D0;
            end
            default: begin
                state_nxt = SCAN_D0;
            end
        endcase
    end

    // Leading-zero suppression applies only to tens positions.
    always_comb begin
`ifdef SEG_BLANK_LEADING_ZERO_EN
        digit_blank = digit_is_tens && (digit_val == 4'd0);
`else
        digit_blank = 1'b0;
        if (digit_is_tens) digit_blank = 1'b0;
`endif
        seg_d = digit_blank ? 7'b1111111 : seg_of(digit_val);
        an_d  = ~(4'b0001 << state);
    end

    // Segments and anode latched together so they never disagree.
    always_ff @(posedge segclk) begin
        if (clr) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: randomized check of seg_display against a digit-level model.
// Runs a DIGIT_HOLD=1 and a DIGIT_HOLD=3 instance on the same inputs.
module tb_seg_display;

    logic        segclk;
    logic        clr;
    logic [14:0] sc;
    logic [6:0]  seg1;
    logic [3:0]  an1;
    logic [6:0]  seg3;
    logic [3:0]  an3;

    int n_cmp;
    int n_bad;

    logic [14:0] m_reg;
    int          m_k;
    logic [6:0]  e_seg1;
    logic [3:0]  e_an1;
    logic [6:0]  e_seg3;
    logic [3:0]  e_an3;
    int          shown1;

    logic [6:0] pat [10];

    seg_display #(.DIGIT_HOLD(1)) dut1 (
        .segclk(segclk), .clr(clr),
        .score0(sc[0]), .score1(sc[1]), .score2(sc[2]),
        .score3(sc[3]), .score4(sc[4]), .score5(sc[5]),
        .score6(sc[6]), .score7(sc[7]), .score8(sc[8]),
        .score9(sc[9]), .score10(sc[10]), .score11(sc[11]),
        .score12(sc[12]), .score13(sc[13]), .score14(sc[14]),
        .seg(seg1), .an(an1)
    );

    seg_display #(.DIGIT_HOLD(3)) dut3 (
        .segclk(segclk), .clr(clr),
        .score0(sc[0]), .score1(sc[1]), .score2(sc[2]),
        .score3(sc[3]), .score4(sc[4]), .score5(sc[5]),
        .score6(sc[6]), .score7(sc[7]), .score8(sc[8]),
        .score9(sc[9]), .score10(sc[10]), .score11(sc[11]),
        .score12(sc[12]), .score13(sc[13]), .score14(sc[14]),
        .seg(seg3), .an(an3)
    );

    initial segclk = 1'b0;
    always #5 segclk = ~segclk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [14:0] r,
                                             input int d);
        int h;
        int m;
        int v;
        h = $countones(r);
        m = 15 - h;
        case (d)
            0:       v = m % 10;
            1:       v = m / 10;
            2:       v = h % 10;
            default: v = h / 10;
        endcase
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if ((d % 2 == 1) && v == 0) return 7'b1111111;
`endif
        return pat[v];
    endfunction

    // One clock edge: advance model, then compare both instances.
    task automatic step();
        int d1;
        int d3;
        if (clr) begin
            e_seg1 = 7'b1111111; e_an1 = 4'b1111;
            e_seg3 = 7'b1111111; e_an3 = 4'b1111;
            m_reg  = '0;
            m_k    = 0;
            shown1 = -1;
        end else begin
            d1 = m_k % 4;
            d3 = (m_k / 3) % 4;
            e_seg1 = digit_seg(m_reg, d1);
            e_an1  = ~(4'b0001 << d1);
            e_seg3 = digit_seg(m_reg, d3);
            e_an3  = ~(4'b0001 << d3);
            shown1 = d1;
            m_reg  = sc;
            m_k++;
        end
        @(posedge segclk);
        #1;
        chk("an_h1", {4'b0, an1}, {4'b0, e_an1});
        chk("seg_h1", {1'b0, seg1}, {1'b0, e_seg1});
        chk("an_h3", {4'b0, an3}, {4'b0, e_an3});
        chk("seg_h3", {1'b0, seg3}, {1'b0, e_seg3});
    endtask

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001;
        pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0010000;
        n_cmp = 0;
        n_bad = 0;
        m_reg = '0;
        m_k = 0;
        shown1 = -1;
        clr = 1'b1;
        sc = 15'($urandom);
        @(negedge segclk);

        for (int i = 0; i < 3; i++) begin
            sc = 15'($urandom);
            step();
        end

        clr = 1'b0;
        sc = 15'b000_0101_0101_0101;
        for (int i = 0; i < 16; i++) step();

        sc = '1;
        for (int i = 0; i < 14; i++) step();

        sc = '0;
        for (int i = 0; i < 14; i++) step();

        for (int i = 0; i < 200; i++) begin
            sc = 15'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < $urandom_range(1, 5); j++) step();
            end else begin
                step();
            end
        end

        begin
            int guard;
            guard = 0;
            while (shown1 != 2 && guard < 8) begin
                step();
                guard++;
            end
            chk("find_d2", {6'b0, 2'(shown1)}, 8'd2);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;

        sc = 15'b000_0000_0011_1111;
        for (int i = 0; i < 8; i++) step();
        sc = 15'b000_0011_1111_1111;
        for (int i = 0; i < 16; i++) step();

        for (int i = 0; i < 300; i++) begin
            sc = 15'($urandom);
            clr = ($urandom_range(0, 40) == 0);
            step();
        end
        clr = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
